// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// architectural register constants.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage : hazard_ctrl_pkg

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID-stage source that depends on a load
// currently in EX. Purely combinational.
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic       id_ex_memread_i,
    input  logic [4:0] id_ex_rt_i,
    input  logic [4:0] if_id_rs_i,
    input  logic [4:0] if_id_rt_i,
    output logic       hazard_o
);

    // A load into r0 writes nothing, so it can never create a dependency.
    assign hazard_o = id_ex_memread_i
                    && (id_ex_rt_i != ZERO_REG)
                    && ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule : load_use_detect

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-stall, branch-flush, multi-cycle
// multiply/divide freeze and load-use interlock, plus a stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_hold,
    output logic             mem_hold,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MD_CNT_W = $clog2(MD_LATENCY);
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(1);

    hz_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]    stall_cycles_q;
    logic                mem_stall;
    logic                load_use;

    load_use_detect u_load_use (
        .id_ex_memread_i (id_ex_memread),
        .id_ex_rt_i      (id_ex_rt),
        .if_id_rs_i      (if_id_rs),
        .if_id_rt_i      (if_id_rt),
        .hazard_o        (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;

    // NOTE: every output and next-state gets a default first so no path
    // through the priority chain can infer a latch.
    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        ex_hold     = 1'b0;
        mem_hold    = 1'b0;

        if (state_q == MD_WAIT) begin
            // The divider keeps counting even while memory stalls the back end.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
            mem_hold    = mem_stall;
            md_cnt_d    = md_cnt_q - 1'b1;
            if (md_cnt_q == MD_LAST) begin
                state_d = RUN;
            end
        end else if (mem_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
            mem_hold    = 1'b1;
        end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (md_start) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
            md_cnt_d    = MD_LOAD;
            state_d     = MD_WAIT;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_flush    = 1'b1;
        end

        // Hold the front end frozen and flushed for as long as reset is low.
        if (!reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_flush    = 1'b1;
            id_flush    = 1'b1;
            ex_hold     = 1'b0;
            mem_hold    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            md_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (!pc_write && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
        end
    end

    assign md_busy      = (state_q == MD_WAIT);
    assign md_done      = md_busy && (md_cnt_q == MD_LAST);
    assign stall_cycles = stall_cycles_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 4;

    // Flag order: pc_write, if_id_write, if_flush, id_flush, ex_hold, mem_hold, md_busy, md_done
    localparam logic [7:0] E_RUN  = 8'b1100_0000;
    localparam logic [7:0] E_RST  = 8'b0011_0000;
    localparam logic [7:0] E_LU   = 8'b0001_0000;
    localparam logic [7:0] E_BR   = 8'b1111_0000;
    localparam logic [7:0] E_MDST = 8'b0000_1000;
    localparam logic [7:0] E_MDW  = 8'b0000_1010;
    localparam logic [7:0] E_MDD  = 8'b0000_1011;
    localparam logic [7:0] E_MEM  = 8'b0000_1100;
    localparam logic [7:0] E_MEMW = 8'b0000_1110;
    localparam logic [7:0] E_MEMD = 8'b0000_1111;

    typedef struct {
        string            tag;
        logic [7:0]       flags;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       if_id_rs, if_id_rt, id_ex_rt;
    logic             id_ex_memread, branch_taken, md_start, mem_req, mem_ready;
    logic             pc_write, if_id_write, if_flush, id_flush;
    logic             ex_hold, mem_hold, md_busy, md_done;
    logic [CNT_W-1:0] stall_cycles;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .id_ex_memread (id_ex_memread),
        .id_ex_rt      (id_ex_rt),
        .branch_taken  (branch_taken),
        .md_start      (md_start),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_flush      (if_flush),
        .id_flush      (id_flush),
        .ex_hold       (ex_hold),
        .mem_hold      (mem_hold),
        .md_busy       (md_busy),
        .md_done       (md_done),
        .stall_cycles  (stall_cycles)
    );

    task automatic step(input string tag, input logic rst_n, input logic mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic md, input logic mq, input logic my,
                        input logic [7:0] flags, input logic [CNT_W-1:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst_n;
        id_ex_memread = mr;
        id_ex_rt      = ert;
        if_id_rs      = rs;
        if_id_rt      = rt;
        branch_taken  = br;
        md_start      = md;
        mem_req       = mq;
        mem_ready     = my;
        e.tag   = tag;
        e.flags = flags;
        e.cnt   = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle presents a full output set; compare against the queue head.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {pc_write, if_id_write, if_flush, id_flush,
                       ex_hold, mem_hold, md_busy, md_done};
                n_vec++;
                if (act !== e.flags || stall_cycles !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, act, stall_cycles, e.flags, e.cnt);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; id_ex_memread = 1'b0; id_ex_rt = '0; if_id_rs = '0; if_id_rt = '0;
        branch_taken = 1'b0; md_start = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        #2 reset = 1'b0;

        //    tag           rst mr  ert    rs     rt     br  md  mq  my   flags   cnt
        step("reset",       0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RST,  4'd0);
        step("idle",        1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,  4'd0);
        step("lu_rs",       1, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, E_LU,   4'd0);
        step("after_lu",    1, 0, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, E_RUN,  4'd1);
        step("lu_rt",       1, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, E_LU,   4'd1);
        step("lu_miss",     1, 1, 5'd5, 5'd6, 5'd7, 0, 0, 0, 0, E_RUN,  4'd2);
        step("lu_noload",   1, 0, 5'd6, 5'd6, 5'd6, 0, 0, 0, 0, E_RUN,  4'd2);
        step("zero_reg",    1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,  4'd2);
        step("br_lu",       1, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, E_BR,   4'd2);
        step("br_md",       1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, E_BR,   4'd2);
        step("after_br",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,  4'd2);
        step("mem_run",     1, 1, 5'd8, 5'd8, 5'd0, 1, 1, 1, 0, E_MEM,  4'd2);
        step("mem_ready",   1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, E_RUN,  4'd3);
        step("md_start",    1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_MDST, 4'd3);
        step("md_ign",      1, 1, 5'd8, 5'd8, 5'd0, 1, 1, 0, 0, E_MDW,  4'd4);
        step("md_wait",     1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_MDW,  4'd5);
        step("md_done",     1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_MDD,  4'd6);
        step("md_after",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,  4'd7);
        step("md2_start",   1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_MDST, 4'd7);
        step("md2_mem1",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, E_MEMW, 4'd8);
        step("md2_mem2",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, E_MEMW, 4'd9);
        step("md2_mem_dn",  1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, E_MEMD, 4'd10);
        step("md2_after",   1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,  4'd11);
        step("sat_0",       1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0, E_LU,   4'd11);
        step("sat_1",       1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0, E_LU,   4'd12);
        step("sat_2",       1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0, E_LU,   4'd13);
        step("sat_3",       1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0, E_LU,   4'd14);
        step("sat_4",       1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0, E_LU,   4'd15);
        step("sat_hold",    1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0, E_LU,   4'd15);
        step("sat_idle",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,  4'd15);
        step("md3_start",   1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_MDST, 4'd15);
        step("md3_wait",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_MDW,  4'd15);
        step("md3_reset",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RST,  4'd0);
        step("md3_rsthold", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RST,  4'd0);
        step("md3_release", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,  4'd0);
        step("md4_start",   1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_MDST, 4'd0);
        step("md4_wait1",   1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_MDW,  4'd1);
        step("md4_wait2",   1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_MDW,  4'd2);
        step("md4_done",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_MDD,  4'd3);
        step("md4_after",   1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,  4'd4);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 32, EX-stage multiply/divide occupancy in cycles; legal range 2..256.
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle performance counter.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 if_id_rs  input  5  rs field of the instruction in ID.
REQ-006 if_id_rt  input  5  rt field of the instruction in ID.
REQ-007 id_ex_memread  input  1  instruction in EX is a load.
REQ-008 id_ex_rt  input  5  destination (rt) of the instruction in EX.
REQ-009 branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-010 md_start  input  1  instruction in EX is a multi-cycle multiply/divide.
REQ-011 mem_req  input  1  MEM stage is issuing a data-memory access.
REQ-012 mem_ready  input  1  data memory completes the access this cycle.
REQ-013 pc_write  output  1  PC load enable.
REQ-014 if_id_write  output  1  IF/ID register load enable.
REQ-015 if_flush  output  1  bubble into IF/ID.
REQ-016 id_flush  output  1  bubble into ID/EX; drives the ID/EX register's flush input.
REQ-017 ex_hold  output  1  hold the EX/MEM register and EX operands.
REQ-018 mem_hold  output  1  hold the MEM/WB register.
REQ-019 md_busy  output  1  high while in MD_WAIT.
REQ-020 md_done  output  1  one-cycle pulse on the last MD_WAIT cycle.
REQ-021 stall_cycles  output  CNT_W  count of cycles with pc_write=0 since reset.

Function
REQ-022 The FSM SHALL have two states, RUN and MD_WAIT, plus a down-counter md_cnt of width clog2(MD_LATENCY).
REQ-023 Default outputs SHALL be pc_write=1, if_id_write=1, all flushes/holds=0, md_busy=0, md_done=0.
REQ-024 Mem stall (any state): mem_req & !mem_ready SHALL force pc_write=0, if_id_write=0, ex_hold=1, mem_hold=1, if_flush=0, id_flush=0; this has top priority.
REQ-025 In RUN under mem stall, branch_taken, md_start and load-use SHALL be ignored and the state SHALL not change.
REQ-026 Branch (RUN, no mem stall): branch_taken SHALL give if_flush=1, id_flush=1, pc_write=1 in the same cycle; it overrides md_start and load-use.
REQ-027 MD start (RUN, no mem stall, no branch): md_start SHALL load md_cnt=MD_LATENCY-1 and move to MD_WAIT; in the start cycle pc_write=0, if_id_write=0, ex_hold=1.
REQ-028 MD_WAIT SHALL drive pc_write=0, if_id_write=0, ex_hold=1, md_busy=1; md_cnt SHALL decrement each cycle, including cycles under mem stall.
REQ-029 MD_WAIT with md_cnt=1 SHALL assert md_done and return to RUN on the next edge; total front-end freeze is exactly MD_LATENCY cycles including the start cycle.
REQ-030 md_start and branch_taken SHALL be ignored in MD_WAIT.
REQ-031 Load-use (RUN, no other event): id_ex_memread & id_ex_rt!=0 & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt) SHALL give pc_write=0, if_id_write=0, id_flush=1 for exactly that cycle; register 0 never stalls.
REQ-032 stall_cycles SHALL increment on every cycle with pc_write=0 and saturate at all-ones.
REQ-033 All outputs except stall_cycles, md_busy and md_done SHALL be combinational from state and inputs.

Reset
REQ-034 While reset=0: state=RUN, md_cnt=0, stall_cycles=0, pc_write=0, if_id_write=0, if_flush=1, id_flush=1, ex_hold=0, mem_hold=0, md_busy=0, md_done=0.
REQ-035 Reset asserted in MD_WAIT SHALL abandon the operation immediately with no md_done pulse.

Structure
REQ-036 The shared package SHALL hold the state encoding (RUN=0, MD_WAIT=1) and the register-number constant ZERO_REG=5'd0.
REQ-037 The load-use comparator SHALL be one sub-module, load_use_detect (purely combinational).

Verification
REQ-038 Load-use: id_ex_memread=1, id_ex_rt=8, if_id_rs=8 -> one cycle of pc_write=0, id_flush=1; stall_cycles=1.
REQ-039 Zero register: id_ex_memread=1, id_ex_rt=0, if_id_rt=0 -> no stall, pc_write=1.
REQ-040 MD, MD_LATENCY=4: md_start pulse -> pc_write=0 for exactly 4 cycles, md_done on the 4th, then RUN.
REQ-041 Branch+load-use in the same cycle -> if_flush=id_flush=1, pc_write=1, no stall.
REQ-042 mem_req=1, mem_ready=0 for 3 cycles during MD_WAIT -> mem_hold=1 for 3 cycles, MD still ends after MD_LATENCY cycles.
REQ-043 Reset pulled low mid-MD_WAIT -> md_busy=0 immediately, stall_cycles=0, no md_done pulse.
